udiv_fixed_core: RTL and testbench

Sequential unsigned fixed-point divider core using restoring shift-subtract, one quotient bit per clock over 14 iterations. It accepts a dividend/divisor pair through a start/done handshake and returns a 10-bit quotient and a 10-bit remainder. It also raises a sticky overflow flag when the quotient does not fit in 10 bits, and a divide-by-zero flag. It sits directly upstream of the divider's overflow detection and result stage, supplying the running quotient and iteration count that stage consumes.

---
 rtl/udiv_fixed_core.sv | 138 +++++++++++++
 tb/tb_udiv_fixed_core.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/udiv_fixed_core.sv
// Sequential unsigned fixed-point divider: restoring shift-subtract, one quotient bit per clock.
// Q = floor((A<<FRAC)/B), R = (A<<FRAC) mod B, with sticky overflow and divide-by-zero flags.
module udiv_fixed_core #(
    parameter int unsigned W    = 10,
    parameter int unsigned FRAC = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] Q,
    output logic [W-1:0] R,
    output logic [3:0]   cnt,
    output logic         ovf,
    output logic         dvz
);

    localparam int unsigned N       = W + FRAC;
    localparam logic [3:0]  LastCnt = 4'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   dvd_q, dvd_d;
    logic [W-1:0]   rr_q, rr_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           ovf_q, ovf_d;
    logic           dvz_q, dvz_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [W:0]     trial;
    logic [W-1:0]   diff;
    logic           qbit;

    // The partial remainder is always below the divisor, so W bits hold it; the
    // shifted-in trial value needs one extra bit for the compare only.
    assign trial = {rr_q, dvd_q[N-1]};
    assign qbit  = (trial >= {1'b0, dvs_q});
    assign diff  = trial[W-1:0] - dvs_q;

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        rr_d    = rr_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        dvz_d   = dvz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    rr_d   = '0;
                    cnt_d  = '0;
                    ovf_d  = 1'b0;
                    busy_d = 1'b1;
                    if (B != '0) begin
                        dvd_d   = {A, {FRAC{1'b0}}};
                        dvs_d   = B;
                        quo_d   = '0;
                        dvz_d   = 1'b0;
                        state_d = StRun;
                    end else begin
                        quo_d   = '1;
                        dvz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                dvd_d = {dvd_q[N-2:0], 1'b0};
                rr_d  = qbit ? diff : trial[W-1:0];
                quo_d = {quo_q[W-2:0], qbit};
                // Any set bit leaving the top of the quotient means it did not fit.
                ovf_d = ovf_q | quo_q[W-1];
                if (cnt_q == LastCnt) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            dvd_q   <= '0;
            rr_q    <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            dvz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            rr_q    <= rr_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            dvz_q   <= dvz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Q    = quo_q;
    assign R    = rr_q;
    assign cnt  = cnt_q;
    assign ovf  = ovf_q;
    assign dvz  = dvz_q;

endmodule

// File: tb/tb_udiv_fixed_core.sv
// Scoreboard bench for udiv_fixed_core: stimulus pushes expected results from an arithmetic
// model; a negedge monitor pops and compares on every done pulse.
module tb_udiv_fixed_core;

    localparam int W    = 10;
    localparam int FRAC = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [3:0]   cnt;
    logic         ovf;
    logic         dvz;

    udiv_fixed_core #(.W(W), .FRAC(FRAC)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a),
        .B     (b),
        .busy  (busy),
        .done  (done),
        .Q     (q),
        .R     (r),
        .cnt   (cnt),
        .ovf   (ovf),
        .dvz   (dvz)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         ovf;
        logic         dvz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Plain arithmetic reference; e0 is the cycle count right after the accepting edge.
    function automatic exp_t model(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input int e0);
        exp_t        e;
        int unsigned num;
        int unsigned quo;
        num = 32'(a_v) * (32'd1 << FRAC);
        if (b_v == '0) begin
            e.q   = 10'h3FF;
            e.r   = '0;
            e.ovf = 1'b0;
            e.dvz = 1'b1;
            e.cyc = e0;
        end else begin
            quo   = num / 32'(b_v);
            e.q   = quo[W-1:0];
            e.r   = 10'(num % 32'(b_v));
            e.ovf = (quo > 32'd1023);
            e.dvz = 1'b0;
            e.cyc = e0 + 14;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no completion", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("Q", 32'(q), 32'(mon_e.q));
                check("R", 32'(r), 32'(mon_e.r));
                check("ovf", 32'(ovf), 32'(mon_e.ovf));
                check("dvz", 32'(dvz), 32'(mon_e.dvz));
                check("done_cycle", cyc, mon_e.cyc);
                check("busy_in_done", 32'(busy), 32'd1);
                if (!mon_e.dvz) check("cnt_at_done", 32'(cnt), 32'd13);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%0b done=%0b after 50 cycles, expected idle", busy, done);
        end
    endtask

    // Waits for IDLE, pulses start for one accepting edge, returns that edge's cycle count.
    task automatic issue(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input bit track,
                         output int e0);
        wait_idle();
        a     = a_v;
        b     = b_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e0    = cyc;
        if (track) sb.push_back(model(a_v, b_v, e0));
    endtask

    initial begin
        int e0;
        int nb;
        int nd;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_outputs", {q, r, cnt, ovf, dvz}, 32'd0);
        rst = 1'b0;

        issue(10'h030, 10'h020, 1'b1, e0);

        // Busy/done window for one division.
        issue(10'h001, 10'h003, 1'b1, e0);
        check("cnt_after_start", 32'(cnt), 32'd0);
        check("busy_after_start", 32'(busy), 32'd1);
        nb = 0;
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            nb += int'(busy);
            nd += int'(done);
        end
        check("busy_cycles", nb, 15);
        check("done_cycles", nd, 1);

        // Overflow boundary and divide-by-zero.
        issue(10'h03F, 10'h001, 1'b1, e0);
        issue(10'h040, 10'h001, 1'b1, e0);
        issue(10'h3FF, 10'h001, 1'b1, e0);
        issue(10'h155, 10'h000, 1'b1, e0);

        // Start held for 20 cycles: second acceptance only at the first IDLE cycle.
        wait_idle();
        a     = 10'h030;
        b     = 10'h020;
        start = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        sb.push_back(model(10'h030, 10'h020, e0));
        sb.push_back(model(10'h030, 10'h020, e0 + 16));
        repeat (16) @(negedge clk);
        check("held_idle_busy", 32'(busy), 32'd0);
        check("held_idle_done", 32'(done), 32'd0);
        check("held_idle_Q", 32'(q), 32'h018);
        check("held_idle_R", 32'(r), 32'd0);
        repeat (4) @(negedge clk);
        start = 1'b0;

        // Reset mid-division: no done, outputs cleared at once.
        issue(10'h030, 10'h020, 1'b0, e0);
        repeat (7) @(posedge clk);
        #1;
        check("cnt_iter7", 32'(cnt), 32'd7);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_outputs", {q, r, cnt, ovf, dvz}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        issue(10'h001, 10'h003, 1'b1, e0);

        // Random operands, back-to-back, with some zero and small divisors.
        for (int i = 0; i < 40; i++) begin
            ra = 10'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1, 2:    rb = 10'($urandom_range(1, 15));
                default: rb = 10'($urandom);
            endcase
            issue(ra, rb, 1'b1, e0);
        end

        wait_idle();
        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
